// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - accumulates a fixed number of products into one handshaked result
//
// Purpose:
//   Sums N_TERMS unsigned products from the upstream multiplier into one
//   AW-bit result. Products are accepted one per cycle with valid/ready.
//   The completed result is held until the consumer takes it.
//
// Build option:
//   PROD_ACCUM_SAT_EN  defined   : a sum past 2^AW-1 clamps to 2^AW-1
//                      undefined : a sum past 2^AW-1 wraps modulo 2^AW
//   ovf is set in both cases. Handshake and latency are the same in both builds.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   clr        synchronous abort; gives the same register values as reset
//   in_valid   prod is valid this cycle
//   in_ready   block can accept prod this cycle (state ACCUM)
//   prod       unsigned product, PW bits
//   out_valid  acc_out holds a completed result (state HOLD)
//   out_ready  consumer takes the result this cycle
//   acc_out    completed unsigned sum, AW bits
//   ovf        overflow during the current or held result
//   term_cnt   products accepted so far in the current result
module prod_accum #(
  parameter  int PW      = 16,
  parameter  int AW      = 24,
  parameter  int N_TERMS = 4,
  localparam int CW      = $clog2(N_TERMS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] acc_out,
  output logic          ovf,
  output logic [CW-1:0] term_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [CW-1:0] LAST_TERM = CW'(N_TERMS - 1);
  localparam logic [CW-1:0] ALL_TERMS = CW'(N_TERMS);

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_out_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [AW:0]   sum_wide;
  logic          sum_carry;
  logic [AW-1:0] sum_d;

  // The sum is one bit wider than the accumulator, so the top bit is the overflow flag.
  assign sum_wide  = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, prod};
  assign sum_carry = sum_wide[AW];

`ifdef PROD_ACCUM_SAT_EN
  // Once clamped, acc_q sits at all-ones. Any further nonzero add carries again,
  // so the value stays clamped.
  assign sum_d = sum_carry ? {AW{1'b1}} : sum_wide[AW-1:0];
`else
  assign sum_d = sum_wide[AW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      acc_out_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (sum_carry) begin
              ovf_q <= 1'b1;
            end
            if (cnt_q == LAST_TERM) begin
              acc_out_q   <= sum_d;
              acc_q       <= '0;
              cnt_q       <= ALL_TERMS;
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          // No same-cycle bypass: in_ready returns only on the cycle after the take.
          if (out_ready) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;
  assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - self-checking bench for prod_accum (default AW and narrow AW=17)
module tb_prod_accum;
  localparam int PW  = 16;
  localparam int N   = 4;
  localparam int AW0 = 24;
  localparam int AW1 = 17;
  localparam int CW  = $clog2(N + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] prod = '0;

  logic           in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [AW0-1:0] acc_out0;
  logic [AW1-1:0] acc_out1;
  logic [CW-1:0]  term_cnt0, term_cnt1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  prod_accum #(.PW(PW), .AW(AW0), .N_TERMS(N)) dut0 (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .prod(prod), .out_valid(out_valid0), .out_ready(out_ready), .acc_out(acc_out0),
    .ovf(ovf0), .term_cnt(term_cnt0)
  );

  prod_accum #(.PW(PW), .AW(AW1), .N_TERMS(N)) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .prod(prod), .out_valid(out_valid1), .out_ready(out_ready), .acc_out(acc_out1),
    .ovf(ovf1), .term_cnt(term_cnt1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a running integer sum per width, a term count and a held flag.
  longint m_acc[2];
  longint m_out[2];
  bit     m_ovf[2];
  int     m_cnt  = 0;
  bit     m_hold = 1'b0;

  function automatic longint max_val(input int k);
    return (k == 0) ? ((longint'(1) << AW0) - 1) : ((longint'(1) << AW1) - 1);
  endfunction

  always @(posedge clk) begin
    if (reset || clr) begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0;
        m_out[k] = 0;
        m_ovf[k] = 1'b0;
      end
      m_cnt  = 0;
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        for (int k = 0; k < 2; k++) begin
          longint s;
          s = m_acc[k] + longint'(prod);
          if (s > max_val(k)) begin
            m_ovf[k] = 1'b1;
`ifdef PROD_ACCUM_SAT_EN
            s = max_val(k);
`else
            s = s % (max_val(k) + 1);
`endif
          end
          if (m_cnt == N - 1) begin
            m_out[k] = s;
            m_acc[k] = 0;
          end else begin
            m_acc[k] = s;
          end
        end
        if (m_cnt == N - 1) begin
          m_cnt  = N;
          m_hold = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
      m_cnt  = 0;
      m_ovf[0] = 1'b0;
      m_ovf[1] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready0",  in_ready0,  !m_hold);
      chk("in_ready1",  in_ready1,  !m_hold);
      chk("out_valid0", out_valid0, m_hold);
      chk("out_valid1", out_valid1, m_hold);
      chk("term_cnt0",  term_cnt0,  m_cnt);
      chk("term_cnt1",  term_cnt1,  m_cnt);
      chk("acc_out0",   acc_out0,   m_out[0]);
      chk("acc_out1",   acc_out1,   m_out[1]);
      chk("ovf0",       ovf0,       m_ovf[0]);
      chk("ovf1",       ovf1,       m_ovf[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    prod     = PW'(v);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (!out_valid0 && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (!out_valid0) begin
      errors++;
      $display("FAIL wait_out_valid: got 0 expected 1 within %0d cycles", budget);
    end
  endtask

  initial begin
    cyc();
    cyc();
    cmp_en = 1'b1;
    chk("reset_in_ready", in_ready0, 1);
    chk("reset_acc_out", acc_out0, 0);
    reset = 1'b0;
    cyc();

    // Four maximum products back-to-back; the narrow instance overflows.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prod      = 16'd65025;
    repeat (4) cyc();
    in_valid = 1'b0;
    chk("t1_out_valid", out_valid0, 1);
    chk("t1_acc_out0", acc_out0, 260100);
    chk("t1_model_out0", m_out[0], 260100);
    chk("t1_ovf0", ovf0, 0);
    chk("t1_ovf1", ovf1, 1);
`ifdef PROD_ACCUM_SAT_EN
    chk("t1_acc_out1_sat", acc_out1, 131071);
`else
    chk("t1_acc_out1_wrap", acc_out1, 129028);
`endif
    cyc();
    chk("t1_in_ready_again", in_ready0, 1);
    chk("t1_ovf1_cleared", ovf1, 0);

    // Bubbles between every term, result then held.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_term_cnt", term_cnt0, i - 1);
      feed(i);
      cyc();
    end
    chk("t2_term_cnt_hold", term_cnt0, 4);
    chk("t2_acc_out", acc_out0, 10);
    in_valid = 1'b1;
    prod     = 16'd99;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_hold_acc", acc_out0, 10);
      chk("t3_hold_in_ready", in_ready0, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    feed(7);
    feed(0);
    feed(0);
    feed(0);
    wait_out(10);
    chk("t3_fresh_sum", acc_out0, 7);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Abort a partial sum with clr, then with reset.
    feed(100);
    feed(200);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t4_clr_cnt", term_cnt0, 0);
    repeat (4) feed(5);
    wait_out(10);
    chk("t4_clr_result", acc_out0, 20);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    feed(100);
    feed(200);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t4_reset_acc_out", acc_out0, 0);
    repeat (4) feed(5);
    wait_out(10);
    chk("t4_reset_result", acc_out0, 20);

    // clr while holding a result.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t5_out_valid", out_valid0, 0);
    chk("t5_acc_out", acc_out0, 0);
    chk("t5_in_ready", in_ready0, 1);
    cyc();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 8x8 combinational multiplier `mult`; takes its 16-bit product stream and sums a fixed number of products into one accumulated result (dot-product / MAC stage).
- Valid/ready handshake on input and output; one product accepted per cycle; result held until the consumer takes it.
- Sits between `mult` (operand pair -> product) and whatever consumes the dot-product result.

Parameters:
- PW, 16, product width; matches `mult` output.
- AW, 24, accumulator/result width; AW >= PW required.
- N_TERMS, 4, products summed per result; N_TERMS >= 1.
- CW, $clog2(N_TERMS+1), term counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- clr  input  1  synchronous abort; discards partial sum and any held result.
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block can accept prod this cycle.
- prod  input  PW  unsigned product from `mult`.
- out_valid  output  1  acc_out holds a completed result.
- out_ready  input  1  consumer takes result this cycle.
- acc_out  output  AW  completed unsigned sum.
- ovf  output  1  overflow occurred during the current or held result.
- term_cnt  output  CW  products accepted so far in the current result.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: state=ACCUM, acc=0, term_cnt=0, acc_out=0, out_valid=0, ovf=0; in_ready=1 in the first cycle after reset.
- Priority: reset > clr > normal operation. clr gives the same register values as reset, in one cycle.
- States: ACCUM and HOLD. in_ready = (state==ACCUM); out_valid = (state==HOLD).
- ACCUM, accept (in_valid & in_ready): sum = acc + zero-extended prod, computed AW+1 bits wide.
  - If sum carries out of AW, the stored sum wraps modulo 2^AW and ovf is set.
  - ovf is sticky until the result is consumed.
- ACCUM, accept with term_cnt < N_TERMS-1: acc <= sum, term_cnt++.
- ACCUM, accept with term_cnt == N_TERMS-1 (final term):
  - acc_out <= sum; acc <= 0; term_cnt <= N_TERMS; go to HOLD.
  - Latency: out_valid asserts the cycle after the final accept.
- ACCUM, no in_valid: all state held. Bubbles are allowed anywhere in the sequence.
- HOLD: acc_out, ovf and term_cnt are stable; prod is ignored (in_ready=0).
- HOLD with out_ready: go to ACCUM; term_cnt <= 0; ovf <= 0; acc_out retains its value.
  - in_ready rises the next cycle; there is no same-cycle bypass, so the minimum gap between results is 1 cycle.
- HOLD without out_ready: stay in HOLD indefinitely.
- N_TERMS=1: every accept goes straight to HOLD with acc_out = prod.
- Max product 255*255 = 65025. The default AW=24 cannot overflow for N_TERMS <= 258.

Optional Feature:
- Macro: PROD_ACCUM_SAT_EN.
- Defined: when the AW+1-bit sum exceeds 2^AW-1, the stored value clamps to 2^AW-1 and ovf is set. Later adds stay clamped.
- Undefined: the stored value wraps modulo 2^AW and ovf is set.
- ovf, handshake and latency are identical in both builds.

Test Plan:
- Reset, then N_TERMS=4 with prod = 65025 x4 back-to-back, out_ready=1 -> out_valid the cycle after the 4th accept; acc_out=260100 (0x03F804); ovf=0; in_ready high again the following cycle.
- prod = 1,2,3,4 with an in_valid bubble between each -> acc_out=10; term_cnt steps 0,1,2,3, then 4 in HOLD; no accepts during bubbles.
- Result 10 held with out_ready=0 for 5 cycles while in_valid=1 -> acc_out stays 10, in_ready=0, no prod absorbed; after out_ready=1, the next result starts from 0.
- AW=17, prod = 65025 x4 -> without macro: acc_out=129028, ovf=1. With PROD_ACCUM_SAT_EN: acc_out=131071, ovf=1. ovf clears after the handshake.
- Accept 2 terms (100, 200), assert clr, then feed 5,5,5,5 -> acc_out=20; repeat with reset instead of clr -> same result.
- Assert clr while in HOLD -> out_valid=0 and acc_out=0 the next cycle; in_ready=1.
